crc_serial_frame: RTL and testbench

Parametrised serial CRC engine, successor to the fixed 16-bit/32-bit-word serial CRC block. It accepts data words over a valid/ready handshake, shifts each word MSB-first through a configurable-width LFSR at one bit per clock, and chains words into multi-word frames delimited by `in_last`. The finished CRC is returned over a second valid/ready handshake. It sits between a word-oriented producer (packetiser, memory reader) and a frame check/append stage.

---
 rtl/crc_serial_pkg.sv | 14 +
 rtl/crc_bit_step.sv | 19 +
 rtl/crc_serial_frame.sv | 116 +++++++++++
 tb/tb_crc_serial_frame.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/crc_serial_pkg.sv
// Shared types and constants for the serial CRC frame engine.
// The optional frame check port is enabled by defining CRC_SERIAL_CHECK_EN.
package crc_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } crc_state_e;

    localparam logic [15:0] CRC_POLY_CCITT = 16'h1021;

endpackage

// File: rtl/crc_bit_step.sv
// One MSB-first LFSR step of a CRC register: shifts in a single data bit.
// Purely combinational; the caller owns the register.
module crc_bit_step
    import crc_serial_pkg::*;
#(
    parameter int                 CRC_W = 16,
    parameter logic [CRC_W-1:0]   POLY  = CRC_W'(CRC_POLY_CCITT)
) (
    input  logic [CRC_W-1:0] crc,
    input  logic             data_bit,
    output logic [CRC_W-1:0] crc_next
);

    logic fb;

    assign fb       = crc[CRC_W-1] ^ data_bit;
    assign crc_next = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc_serial_frame.sv
// Serial bit-per-clock CRC engine chaining words into in_last-delimited frames.
// Define CRC_SERIAL_CHECK_EN to add the chk_crc input and out_ok compare output.
module crc_serial_frame
    import crc_serial_pkg::*;
#(
    parameter int               DATA_W  = 32,
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC_POLY_CCITT),
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] XOR_OUT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  out_crc,
`ifdef CRC_SERIAL_CHECK_EN
    input  logic [CRC_W-1:0]  chk_crc,
    output logic              out_ok,
`endif
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]        state;
    logic [CRC_W-1:0]  crc_q;
    logic [CRC_W-1:0]  crc_next;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              last_q;
    logic              accept;

    crc_bit_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .crc      (crc_q),
        .data_bit (shreg[DATA_W-1]),
        .crc_next (crc_next)
    );

    assign in_ready  = (state == ST_IDLE) || (state == ST_WAIT);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign out_crc   = crc_q ^ XOR_OUT;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            crc_q  <= INIT;
            // NOTE: datapath registers are reset too; they are few and cheap,
            // and it keeps every output free of X straight out of reset.
            shreg  <= '0;
            cnt    <= '0;
            last_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_WAIT: begin
                    if (accept) begin
                        shreg  <= in_data;
                        last_q <= in_last;
                        cnt    <= CNT_W'(DATA_W - 1);
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    crc_q <= crc_next;
                    shreg <= shreg << 1;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= last_q ? ST_DONE : ST_WAIT;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        crc_q <= INIT;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    crc_q <= INIT;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CRC_SERIAL_CHECK_EN
    logic [CRC_W-1:0] chk_q;

    // Reference CRC is captured with the frame's last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q <= '0;
        end else if (accept && in_last) begin
            chk_q <= chk_crc;
        end
    end

    assign out_ok = out_valid && (out_crc == chk_q);
`endif

endmodule

// File: tb/tb_crc_serial_frame.sv
// Directed bench for crc_serial_frame: 8-bit words, CRC-16/CCITT with INIT 0000 and FFFF.
// Checks single-word vectors, a 9-byte frame, back-pressure, ignored valid and mid-frame reset.
module tb_crc_serial_frame;

    localparam int DATA_W = 8;
    localparam int CRC_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_last;
    logic              out_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_ready0, in_ready1;
    logic              out_valid0, out_valid1;
    logic              busy0, busy1;
    logic [CRC_W-1:0]  crc0, crc1;
`ifdef CRC_SERIAL_CHECK_EN
    logic [CRC_W-1:0]  chk_crc;
    logic              ok0, ok1;
`endif

    always #5 clk = ~clk;

    crc_serial_frame #(
        .DATA_W(DATA_W), .CRC_W(CRC_W), .POLY(16'h1021), .INIT(16'h0000), .XOR_OUT(16'h0000)
    ) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready), .out_crc(crc0),
`ifdef CRC_SERIAL_CHECK_EN
        .chk_crc(chk_crc), .out_ok(ok0),
`endif
        .busy(busy0)
    );

    crc_serial_frame #(
        .DATA_W(DATA_W), .CRC_W(CRC_W), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000)
    ) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready), .out_crc(crc1),
`ifdef CRC_SERIAL_CHECK_EN
        .chk_crc(chk_crc), .out_ok(ok1),
`endif
        .busy(busy1)
    );

    typedef struct {
        logic [7:0]  data;
        logic [15:0] exp_crc;
    } vec_t;

    int errors = 0;
    int checks = 0;
    logic [7:0] msg [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready0 && n < 200) begin
            cyc();
            n++;
        end
        check("in_ready_before_accept", 32'(in_ready0), 32'd1);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic send_msg();
        for (int i = 0; i < 9; i++) send_word(msg[i], i == 8);
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid0 && n < 400) begin
            cyc();
            n++;
        end
        check("out_valid_wait", 32'(out_valid0), 32'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("in_ready_after_handshake", 32'(in_ready0), 32'd1);
        check("out_valid_after_handshake", 32'(out_valid0), 32'd0);
    endtask

    initial begin
        vec_t vecs [6];
        logic [15:0] held0, held1;
        logic        stable;
        logic        rdy;
        int          acc;
        int          n;

        vecs[0] = '{8'h00, 16'h0000};
        vecs[1] = '{8'h01, 16'h1021};
        vecs[2] = '{8'h02, 16'h2042};
        vecs[3] = '{8'h20, 16'h2462};
        vecs[4] = '{8'h80, 16'h9188};
        vecs[5] = '{8'hFF, 16'h1EF0};
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
`ifdef CRC_SERIAL_CHECK_EN
        chk_crc = '0;
`endif
        cyc(); cyc();
        rst = 1'b0;

        check("reset_in_ready", 32'(in_ready0), 32'd1);
        check("reset_out_valid", 32'(out_valid0), 32'd0);
        check("reset_busy", 32'(busy0), 32'd0);
        check("reset_crc_init0", 32'(crc0), 32'h0000);
        check("reset_crc_initffff", 32'(crc1), 32'hFFFF);

        // Single-word frames: CRC value and accept-to-out_valid latency.
        for (int i = 0; i < 6; i++) begin
            send_word(vecs[i].data, 1'b1);
            check("shift_in_ready_low", 32'(in_ready0), 32'd0);
            check("shift_busy", 32'(busy0), 32'd1);
            n = 0;
            while (!out_valid0 && n < 50) begin
                cyc();
                n++;
            end
            check("single_word_latency", 32'(n), 32'd8);
            check("single_word_crc", 32'(crc0), 32'(vecs[i].exp_crc));
            handshake();
        end

        // Full frame, then 20 cycles of back-pressure.
        send_msg();
        wait_out();
        check("frame_crc_init0", 32'(crc0), 32'h31C3);
        check("frame_crc_initffff", 32'(crc1), 32'h29B1);
        held0 = crc0; held1 = crc1; stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (!out_valid0 || !out_valid1 || crc0 !== held0 || crc1 !== held1 || in_ready0)
                stable = 1'b0;
        end
        check("backpressure_stable", 32'(stable), 32'd1);
        check("backpressure_crc", 32'(crc1), 32'h29B1);
        handshake();

        // in_valid held high with garbage while not ready must not be accepted.
        acc = 0; n = 0; in_valid = 1'b1;
        while (acc < 9 && n < 500) begin
            if (in_ready0) begin
                in_data = msg[acc];
                in_last = (acc == 8);
            end else begin
                in_data = 8'($urandom);
                in_last = 1'($urandom);
            end
            rdy = in_ready0;
            cyc();
            n++;
            if (rdy) acc++;
        end
        check("held_valid_accepts", 32'(acc), 32'd9);
        n = 0;
        while (!out_valid0 && n < 50) begin
            in_data = 8'($urandom);
            in_last = 1'($urandom);
            cyc();
            n++;
        end
        in_valid = 1'b0;
        check("held_valid_crc", 32'(crc0), 32'h31C3);
        check("held_valid_crc_ffff", 32'(crc1), 32'h29B1);
        handshake();

        // Reset in the middle of word 5, then a clean frame.
        for (int i = 0; i < 5; i++) send_word(msg[i], 1'b0);
        cyc(); cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midreset_in_ready", 32'(in_ready0), 32'd1);
        check("midreset_out_valid", 32'(out_valid0), 32'd0);
        check("midreset_busy", 32'(busy0), 32'd0);
        check("midreset_crc", 32'(crc0), 32'h0000);
        send_msg();
        wait_out();
        check("after_reset_crc", 32'(crc0), 32'h31C3);
        handshake();

`ifdef CRC_SERIAL_CHECK_EN
        chk_crc = 16'h31C3;
        send_msg();
        wait_out();
        check("check_ok_match", 32'(ok0), 32'd1);
        handshake();
        check("check_ok_idle", 32'(ok0), 32'd0);
        chk_crc = 16'h31C2;
        send_msg();
        wait_out();
        check("check_ok_mismatch", 32'(ok0), 32'd0);
        handshake();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
